// File: rtl/sram_arb_pkg.sv
// Shared types and default address map for the SRAM port arbiter.
package sram_arb_pkg;

    typedef enum logic [2:0] {IDLE, LO, GAP, HI, DONE} arb_state_t;
    typedef enum logic {GNT_WRITE, GNT_READ} grant_t;

    localparam logic [15:0] DEF_START_ADDR = 16'h0000;
    localparam logic [15:0] DEF_LAST_ADDR  = 16'h1b90;
    localparam logic [15:0] DEF_ADDR_STEP  = 16'd16;
    localparam logic [15:0] DEF_RD_OFFSET  = 16'h0020;

    // Next word base; wraps early so the high half never lands past last.
    function automatic logic [15:0] ring_next(input logic [15:0] ptr,
                                              input logic [15:0] start,
                                              input logic [15:0] last,
                                              input logic [15:0] step);
        logic [15:0] nxt;
        logic [16:0] top;
        nxt = ptr + (step << 1);
        top = {1'b0, nxt} + {1'b0, step};
        if (top > {1'b0, last}) begin
            nxt = start;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/sram_ring_ptr.sv
// Circular buffer pointer: holds a word base address, advances one word per strobe.
module sram_ring_ptr
    import sram_arb_pkg::*;
#(
    parameter logic [15:0] RESET_VAL  = DEF_START_ADDR,
    parameter logic [15:0] START_ADDR = DEF_START_ADDR,
    parameter logic [15:0] LAST_ADDR  = DEF_LAST_ADDR,
    parameter logic [15:0] ADDR_STEP  = DEF_ADDR_STEP
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        advance,
    output logic [15:0] ptr
);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ptr <= RESET_VAL;
        end else if (advance) begin
            ptr <= ring_next(ptr, START_ADDR, LAST_ADDR, ADDR_STEP);
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Round-robin sharing of the 16-bit SRAM port between the 32-bit sample
// write and delayed-sample read channels; each transaction is two half-word accesses.
//
// state | meaning
// IDLE  | no transaction; arbitrate and grant when hold=0
// LO    | access low half at ptr
// GAP   | enables low between the two halves
// HI    | access high half at ptr + ADDR_STEP
// DONE  | ack/valid pulse, granted pointer advances
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter logic [15:0] START_ADDR = DEF_START_ADDR,
    parameter logic [15:0] LAST_ADDR  = DEF_LAST_ADDR,
    parameter logic [15:0] ADDR_STEP  = DEF_ADDR_STEP,
    parameter logic [15:0] RD_OFFSET  = DEF_RD_OFFSET
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        hold,
    input  logic        wr_req,
    input  logic [31:0] wr_data,
    output logic        wr_ack,
    input  logic        rd_req,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic        busy,
    output logic [15:0] sram_addr,
    output logic        sram_r_en,
    output logic        sram_w_en,
    output logic [15:0] sram_wdata,
    input  logic [15:0] sram_rdata
);

    localparam logic [15:0] RD_RESET = START_ADDR + RD_OFFSET;

    arb_state_t  state, state_nxt;
    grant_t      gnt, gnt_nxt;
    grant_t      rr_last, rr_last_nxt;
    logic        grant_now;
    logic [31:0] wr_buf;
    logic [15:0] rd_lo;
    logic [15:0] wr_ptr, rd_ptr, ptr_sel;
    logic        wr_adv, rd_adv;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= IDLE;
            gnt      <= GNT_WRITE;
            rr_last  <= GNT_READ;
            wr_buf   <= '0;
            rd_lo    <= '0;
            rd_data  <= '0;
            wr_ack   <= 1'b0;
            rd_valid <= 1'b0;
        end else begin
            state    <= state_nxt;
            gnt      <= gnt_nxt;
            rr_last  <= rr_last_nxt;
            if (grant_now && gnt_nxt == GNT_WRITE) begin
                wr_buf <= wr_data;
            end
            if (state == LO && gnt == GNT_READ) begin
                rd_lo <= sram_rdata;
            end
            if (state == HI && gnt == GNT_READ) begin
                rd_data <= {sram_rdata, rd_lo};
            end
            wr_ack   <= (state == HI) && (gnt == GNT_WRITE);
            rd_valid <= (state == HI) && (gnt == GNT_READ);
        end
    end

    always_comb begin
        state_nxt   = state;
        gnt_nxt     = gnt;
        rr_last_nxt = rr_last;
        grant_now   = 1'b0;
        unique case (state)
            IDLE: begin
                if (!hold && (wr_req || rd_req)) begin
                    grant_now = 1'b1;
                    state_nxt = LO;
                    // On contention the channel not served last wins.
                    if (wr_req && (!rd_req || rr_last == GNT_READ)) begin
                        gnt_nxt = GNT_WRITE;
                    end else begin
                        gnt_nxt = GNT_READ;
                    end
                    rr_last_nxt = gnt_nxt;
                end
            end
            LO:      state_nxt = GAP;
            GAP:     state_nxt = HI;
            HI:      state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ptr_sel    = (gnt == GNT_WRITE) ? wr_ptr : rd_ptr;
        sram_addr  = START_ADDR;
        sram_r_en  = 1'b0;
        sram_w_en  = 1'b0;
        sram_wdata = '0;
        unique case (state)
            LO: begin
                sram_addr = ptr_sel;
                if (gnt == GNT_WRITE) begin
                    sram_w_en  = 1'b1;
                    sram_wdata = wr_buf[15:0];
                end else begin
                    sram_r_en = 1'b1;
                end
            end
            GAP: sram_addr = ptr_sel + ADDR_STEP;
            HI: begin
                sram_addr = ptr_sel + ADDR_STEP;
                if (gnt == GNT_WRITE) begin
                    sram_w_en  = 1'b1;
                    sram_wdata = wr_buf[31:16];
                end else begin
                    sram_r_en = 1'b1;
                end
            end
            default: sram_addr = START_ADDR;
        endcase
    end

    assign busy   = (state != IDLE);
    assign wr_adv = (state == DONE) && (gnt == GNT_WRITE);
    assign rd_adv = (state == DONE) && (gnt == GNT_READ);

    sram_ring_ptr #(
        .RESET_VAL  (START_ADDR),
        .START_ADDR (START_ADDR),
        .LAST_ADDR  (LAST_ADDR),
        .ADDR_STEP  (ADDR_STEP)
    ) u_wr_ptr (
        .clk     (clk),
        .n_rst   (n_rst),
        .advance (wr_adv),
        .ptr     (wr_ptr)
    );

    sram_ring_ptr #(
        .RESET_VAL  (RD_RESET),
        .START_ADDR (START_ADDR),
        .LAST_ADDR  (LAST_ADDR),
        .ADDR_STEP  (ADDR_STEP)
    ) u_rd_ptr (
        .clk     (clk),
        .n_rst   (n_rst),
        .advance (rd_adv),
        .ptr     (rd_ptr)
    );

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench: a transaction-level arbiter model predicts every SRAM access
// and every ack/valid; a negedge monitor compares them against the DUT.
module tb_sram_port_arbiter;

    localparam int START  = 0;
    localparam int LAST   = 'h1b90;
    localparam int STEP   = 16;
    localparam int RD_OFF = 'h20;

    typedef struct {
        int          cyc;
        logic [15:0] addr;
        bit          wr;
        logic [15:0] wdata;
    } acc_t;

    typedef struct {
        int          cyc;
        bit          wr;
        logic [31:0] data;
    } done_t;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        hold;
    logic        wr_req;
    logic [31:0] wr_data;
    logic        wr_ack;
    logic        rd_req;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        busy;
    logic [15:0] sram_addr;
    logic        sram_r_en;
    logic        sram_w_en;
    logic [15:0] sram_wdata;
    logic [15:0] sram_rdata;

    sram_port_arbiter dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .hold       (hold),
        .wr_req     (wr_req),
        .wr_data    (wr_data),
        .wr_ack     (wr_ack),
        .rd_req     (rd_req),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .busy       (busy),
        .sram_addr  (sram_addr),
        .sram_r_en  (sram_r_en),
        .sram_w_en  (sram_w_en),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    always #5 clk = ~clk;

    // SRAM behavioural model; undriven read data is junk to expose mistimed capture.
    logic [15:0] mem [0:65535];
    always @(posedge clk) if (sram_w_en) mem[sram_addr] <= sram_wdata;
    assign sram_rdata = sram_r_en ? mem[sram_addr] : 16'hEEEE;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model state
    logic [15:0] model_mem [0:65535];
    acc_t        acc_q[$];
    done_t       done_q[$];
    int          cyc = 0;
    int          busy_left = 0;
    bit          last_was_rd = 1'b1;
    int          m_wp = START;
    int          m_rp = START + RD_OFF;
    bit          have_grant = 1'b0;
    int          g_cyc = 0;
    bit          m_do_wr;
    int          abort_addr = 0;
    logic [15:0] abort_old = '0;
    int          wr_wraps = 0;
    int          rd_wraps = 0;
    acc_t        m_a;
    done_t       m_d;

    function automatic int next_ptr(input int p);
        int n;
        n = p + 2 * STEP;
        if (n + STEP > LAST) n = START;
        return n;
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (n_rst) begin
            if (busy_left > 0) begin
                busy_left--;
            end else if (!hold && (wr_req || rd_req)) begin
                m_do_wr     = wr_req && (!rd_req || last_was_rd);
                last_was_rd = !m_do_wr;
                have_grant  = 1'b1;
                g_cyc       = cyc;
                busy_left   = 4;
                if (m_do_wr) begin
                    m_a.wr = 1'b1;
                    m_a.cyc = cyc;     m_a.addr = 16'(m_wp);        m_a.wdata = wr_data[15:0];
                    acc_q.push_back(m_a);
                    m_a.cyc = cyc + 2; m_a.addr = 16'(m_wp + STEP); m_a.wdata = wr_data[31:16];
                    acc_q.push_back(m_a);
                    abort_addr = m_wp + STEP;
                    abort_old  = model_mem[m_wp + STEP];
                    model_mem[m_wp]        = wr_data[15:0];
                    model_mem[m_wp + STEP] = wr_data[31:16];
                    m_d.cyc = cyc + 3; m_d.wr = 1'b1; m_d.data = '0;
                    done_q.push_back(m_d);
                    m_wp = next_ptr(m_wp);
                    if (m_wp == START) wr_wraps++;
                end else begin
                    m_a.wr = 1'b0; m_a.wdata = '0;
                    m_a.cyc = cyc;     m_a.addr = 16'(m_rp);
                    acc_q.push_back(m_a);
                    m_a.cyc = cyc + 2; m_a.addr = 16'(m_rp + STEP);
                    acc_q.push_back(m_a);
                    m_d.cyc = cyc + 3; m_d.wr = 1'b0;
                    m_d.data = {model_mem[m_rp + STEP], model_mem[m_rp]};
                    done_q.push_back(m_d);
                    m_rp = next_ptr(m_rp);
                    if (m_rp == START) rd_wraps++;
                end
            end
        end
    end

    // Monitor
    bit    prev_en = 1'b0;
    bit    mon_en;
    bit    exp_busy;
    acc_t  mon_a;
    done_t mon_d;

    always @(negedge clk) begin
        if (!n_rst) begin
            prev_en = 1'b0;
        end else begin
            mon_en = sram_r_en || sram_w_en;
            if (prev_en) chk("enable_gap", 32'(mon_en), 32'd0);
            if (mon_en) begin
                if (acc_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_access: got addr %h w_en %b at cycle %0d, required no access",
                             sram_addr, sram_w_en, cyc);
                end else begin
                    mon_a = acc_q.pop_front();
                    chk("access_cycle", 32'(cyc), 32'(mon_a.cyc));
                    chk("access_addr", 32'(sram_addr), 32'(mon_a.addr));
                    chk("access_kind_w", 32'(sram_w_en), 32'(mon_a.wr));
                    chk("access_kind_r", 32'(sram_r_en), 32'(!mon_a.wr));
                    if (mon_a.wr) chk("access_wdata", 32'(sram_wdata), 32'(mon_a.wdata));
                end
            end else if (acc_q.size() > 0 && acc_q[0].cyc < cyc) begin
                mon_a = acc_q.pop_front();
                n_checks++; n_fail++;
                $display("FAIL missed_access: got none, required addr %h at cycle %0d", mon_a.addr, mon_a.cyc);
            end
            if (!sram_w_en) chk("wdata_zero_when_idle", 32'(sram_wdata), 32'd0);
            exp_busy = have_grant && (cyc >= g_cyc) && (cyc <= g_cyc + 3);
            chk("busy", 32'(busy), 32'(exp_busy));
            if (wr_ack || rd_valid) begin
                if (done_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_done: got wr_ack %b rd_valid %b at cycle %0d, required none",
                             wr_ack, rd_valid, cyc);
                end else begin
                    mon_d = done_q.pop_front();
                    chk("done_cycle", 32'(cyc), 32'(mon_d.cyc));
                    chk("done_wr_ack", 32'(wr_ack), 32'(mon_d.wr));
                    chk("done_rd_valid", 32'(rd_valid), 32'(!mon_d.wr));
                    if (!mon_d.wr) chk("rd_data", rd_data, mon_d.data);
                end
            end else if (done_q.size() > 0 && done_q[0].cyc < cyc) begin
                mon_d = done_q.pop_front();
                n_checks++; n_fail++;
                $display("FAIL missed_done: got none, required wr=%b at cycle %0d", mon_d.wr, mon_d.cyc);
            end
            prev_en = mon_en;
        end
    end

    // Requesters: call at #1 after a posedge; each returns at #1 after a posedge.
    task automatic do_write(input logic [31:0] d);
        bit got;
        got = 1'b0;
        wr_data = d;
        wr_req  = 1'b1;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if (wr_ack) got = 1'b1;
            else begin
                @(posedge clk); #1;
                if (busy) wr_data = $urandom;
            end
        end
        if (!got) begin
            n_checks++; n_fail++;
            $display("FAIL write_ack_timeout: got no wr_ack, required one within 300 cycles");
        end
        @(posedge clk); #1;
        wr_req  = 1'b0;
        wr_data = $urandom;
    endtask

    task automatic do_read();
        bit got;
        got = 1'b0;
        rd_req = 1'b1;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if (rd_valid) got = 1'b1;
        end
        if (!got) begin
            n_checks++; n_fail++;
            $display("FAIL read_valid_timeout: got no rd_valid, required one within 300 cycles");
        end
        @(posedge clk); #1;
        rd_req = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_sram_addr"}, 32'(sram_addr), 32'(START));
        chk({tag, "_sram_r_en"}, 32'(sram_r_en), 32'd0);
        chk({tag, "_sram_w_en"}, 32'(sram_w_en), 32'd0);
        chk({tag, "_sram_wdata"}, 32'(sram_wdata), 32'd0);
        chk({tag, "_wr_ack"}, 32'(wr_ack), 32'd0);
        chk({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_rd_data"}, rd_data, 32'd0);
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && (acc_q.size() > 0 || done_q.size() > 0); i++) @(posedge clk);
        if (acc_q.size() > 0 || done_q.size() > 0) begin
            n_checks++; n_fail++;
            $display("FAIL drain_timeout: got %0d accesses and %0d completions pending, required 0",
                     acc_q.size(), done_q.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    bit rand_done = 1'b0;

    initial begin
        n_rst = 1'b0; hold = 1'b0; wr_req = 1'b0; rd_req = 1'b0; wr_data = '0;
        for (int i = 0; i < 65536; i++) begin
            mem[i]       = 16'(i * 7 + 3) ^ 16'h5a5a;
            model_mem[i] = mem[i];
        end
        mem[16'h0020] = 16'h1234; model_mem[16'h0020] = 16'h1234;
        mem[16'h0030] = 16'hABCD; model_mem[16'h0030] = 16'hABCD;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        n_rst = 1'b1;
        @(posedge clk); #1;

        // Directed write then read
        do_write(32'hDEAD_BEEF);
        chk("first_write_lo", 32'(mem[16'h0000]), 32'h0000_BEEF);
        chk("first_write_hi", 32'(mem[16'h0010]), 32'h0000_DEAD);
        do_read();
        chk("first_read_data", rd_data, 32'hABCD_1234);
        repeat (3) @(posedge clk);
        #1;
        chk("rd_data_holds", rd_data, 32'hABCD_1234);

        // Both requesters held high: strict alternation
        fork
            begin repeat (2) do_write($urandom); end
            begin repeat (2) do_read(); end
        join
        drain();

        // hold while pending, then hold raised during GAP
        hold = 1'b1;
        fork
            do_write(32'h1357_9BDF);
            do_read();
            begin
                repeat (10) begin @(posedge clk); #1; end
                chk("hold_busy", 32'(busy), 32'd0);
                chk("hold_no_w_en", 32'(sram_w_en), 32'd0);
                hold = 1'b0;
                @(posedge clk);
                @(posedge clk); #1;
                hold = 1'b1;
                repeat (8) begin @(posedge clk); #1; end
                hold = 1'b0;
            end
        join
        drain();

        // Random traffic with random hold; long enough for both pointers to wrap
        fork
            begin
                fork
                    begin
                        int gap_w;
                        repeat (240) begin
                            do_write($urandom);
                            gap_w = $urandom_range(0, 3);
                            repeat (gap_w) begin @(posedge clk); #1; end
                        end
                    end
                    begin
                        int gap_r;
                        repeat (240) begin
                            do_read();
                            gap_r = $urandom_range(0, 3);
                            repeat (gap_r) begin @(posedge clk); #1; end
                        end
                    end
                join
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk); #1;
                    hold = ($urandom_range(0, 7) == 0);
                end
                hold = 1'b0;
            end
        join
        drain();
        chk("wr_ptr_wrapped", 32'(wr_wraps > 0), 32'd1);

        // Reset asserted while the write is in HI
        wr_data = 32'h5555_AAAA;
        wr_req  = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk); #2;
        n_rst  = 1'b0;
        wr_req = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        acc_q.delete();
        done_q.delete();
        model_mem[abort_addr] = abort_old;
        chk("abort_lo_written", 32'(mem[abort_addr - STEP]), 32'h0000_AAAA);
        chk("abort_hi_untouched", 32'(mem[abort_addr]), 32'(abort_old));
        m_wp = START; m_rp = START + RD_OFF;
        last_was_rd = 1'b1; busy_left = 0; have_grant = 1'b0;
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        do_write(32'h0BAD_F00D);
        chk("post_reset_write_lo", 32'(mem[16'h0000]), 32'h0000_F00D);
        chk("post_reset_write_hi", 32'(mem[16'h0010]), 32'h0000_0BAD);
        do_read();
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no end of test, required finish within 50000 cycles");
        $fatal(1, "timeout");
    end

endmodule
